instruction_fetch_stage: RTL and testbench

- IF stage of the 5-stage MIPS pipeline plus the IF/ID pipeline register; feeds the ID-stage control/decode logic.
- Owns the PC. Issues instruction-memory addresses and registers the fetched word with its PC+4 for ID.
- Applies ID-resolved jump/branch redirects, including target computation, and honours the ID load-use stall (WPCIR).
- Inserts bubbles when instruction memory is not ready.

---
 rtl/instruction_fetch_stage_pkg.sv | 34 +++
 rtl/instruction_fetch_stage_next_pc_select.sv | 60 ++++++
 rtl/instruction_fetch_stage.sv | 77 +++++++
 tb/tb_instruction_fetch_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and types for the MIPS IF stage and IF/ID register.
package instruction_fetch_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned JIDX_W    = 26;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned IFID_SEL_W = 2;

  localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IF/ID payload as carried down the pipe
  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc_4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instruction: NOP_WORD, pc_4: 32'h0, valid: 1'b0};

  // What the IF/ID register does on the coming edge
  typedef enum logic [IFID_SEL_W-1:0] {
    SEL_HOLD   = 2'd0,
    SEL_LOAD   = 2'd1,
    SEL_BUBBLE = 2'd2
  } ifid_sel_e;

  // Sign-extended, word-scaled branch displacement
  function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{14{imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_next_pc_select.sv
// Redirect target computation and next-PC / IF/ID select priority mux.
// FETCH_BRANCH_FLUSH_EN: when defined, the delay-slot word is squashed on a taken redirect.
module next_pc_select
  import instruction_fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] id_pc_4,
  input  logic [15:0] branch_imm,
  input  logic        id_valid,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic        isJumpIndex,
  input  logic [25:0] jumpIndex,
  input  logic        isJumpRegister,
  input  logic [29:0] rs_word,
  input  logic        imemReady,
  output logic [31:0] next_pc_c,
  output logic [31:0] pc_4_c,
  output logic [1:0]  ifid_sel_c
);

  logic [31:0] target_c;
  logic        redirect_c;

  // Jump/branch target; a redirect only counts against a real instruction in ID
  always_comb begin
    target_c   = id_pc_4 + branch_offset(branch_imm);
    redirect_c = shouldJumpOrBranch & id_valid;
    if (isJumpIndex) begin
      target_c = {id_pc_4[31:28], jumpIndex, 2'b00};
    end else if (isJumpRegister) begin
      target_c = {rs_word, 2'b00};
    end
  end

  // Priority: stall > redirect > imem ready > bubble
  always_comb begin
    pc_4_c     = pc + PC_INCR;
    next_pc_c  = pc;
    ifid_sel_c = SEL_HOLD;
    if (shouldStall) begin
      next_pc_c  = pc;
      ifid_sel_c = SEL_HOLD;
    end else if (redirect_c) begin
      next_pc_c = target_c;
`ifdef FETCH_BRANCH_FLUSH_EN
      ifid_sel_c = SEL_BUBBLE;
`else
      ifid_sel_c = imemReady ? SEL_LOAD : SEL_BUBBLE;
`endif
    end else if (imemReady) begin
      next_pc_c  = pc_4_c;
      ifid_sel_c = SEL_LOAD;
    end else begin
      next_pc_c  = pc;
      ifid_sel_c = SEL_BUBBLE;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC register, IF/ID pipeline register and fetched-instruction counter.
// FETCH_BRANCH_FLUSH_EN: when defined, taken redirects squash the delay slot.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shouldStall,
  input  logic                     shouldJumpOrBranch,
  input  logic                     isJumpIndex,
  input  logic [25:0]              jumpIndex,
  input  logic                     isJumpRegister,
  input  logic [31:0]              registerRs,
  output logic [31:0]              imemAddress,
  input  logic [31:0]              imemData,
  input  logic                     imemReady,
  output logic [31:0]              pc,
  output logic [31:0]              id_instruction,
  output logic [31:0]              id_pc_4,
  output logic                     id_valid,
  output logic [COUNTER_WIDTH-1:0] fetchedCount
);

  logic [31:0] next_pc_c;
  logic [31:0] pc_4_c;
  logic [1:0]  ifid_sel_c;
  ifid_t       ifid_q;
  logic        unused_rs_low;

  // JR targets are word-aligned, so the low rs bits are dropped
  assign unused_rs_low = ^registerRs[1:0];

  assign imemAddress    = pc;
  assign id_instruction = ifid_q.instruction;
  assign id_pc_4        = ifid_q.pc_4;
  assign id_valid       = ifid_q.valid;

  next_pc_select u_next_pc_select (
    .pc                 (pc),
    .id_pc_4            (ifid_q.pc_4),
    .branch_imm         (ifid_q.instruction[15:0]),
    .id_valid           (ifid_q.valid),
    .shouldStall        (shouldStall),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .isJumpIndex        (isJumpIndex),
    .jumpIndex          (jumpIndex),
    .isJumpRegister     (isJumpRegister),
    .rs_word            (registerRs[31:2]),
    .imemReady          (imemReady),
    .next_pc_c          (next_pc_c),
    .pc_4_c             (pc_4_c),
    .ifid_sel_c         (ifid_sel_c)
  );

  // PC, IF/ID and counter update
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      ifid_q       <= IFID_BUBBLE;
      fetchedCount <= '0;
    end else begin
      pc <= next_pc_c;
      case (ifid_sel_c)
        SEL_LOAD: begin
          ifid_q       <= '{instruction: imemData, pc_4: pc_4_c, valid: 1'b1};
          fetchedCount <= fetchedCount + COUNTER_WIDTH'(1);
        end
        SEL_BUBBLE: ifid_q <= IFID_BUBBLE;
        default:    ifid_q <= ifid_q;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage against a behavioural model.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, shouldStall, shouldJumpOrBranch, isJumpIndex, isJumpRegister, imemReady;
  logic [25:0] jumpIndex;
  logic [31:0] registerRs, imemData, imemAddress, pc, id_instruction, id_pc_4;
  logic        id_valid;
  logic [31:0] fetchedCount;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  logic [31:0] m_pc, m_ins, m_pc4, m_cnt;
  logic        m_val;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk(clk), .rst(rst), .shouldStall(shouldStall), .shouldJumpOrBranch(shouldJumpOrBranch),
    .isJumpIndex(isJumpIndex), .jumpIndex(jumpIndex), .isJumpRegister(isJumpRegister),
    .registerRs(registerRs), .imemAddress(imemAddress), .imemData(imemData), .imemReady(imemReady),
    .pc(pc), .id_instruction(id_instruction), .id_pc_4(id_pc_4), .id_valid(id_valid),
    .fetchedCount(fetchedCount)
  );

  // Drive one cycle of inputs, advance the model by the stage's rules, then clock
  task automatic step(input logic r, input logic st, input logic sjb, input logic ji_en,
                      input logic [25:0] ji, input logic jr_en, input logic [31:0] rs,
                      input logic [31:0] data, input logic rdy);
    logic [31:0] tgt;
    logic [31:0] nxt;
    logic        ld;
    logic        upd;
    rst = r; shouldStall = st; shouldJumpOrBranch = sjb; isJumpIndex = ji_en; jumpIndex = ji;
    isJumpRegister = jr_en; registerRs = rs; imemData = data; imemReady = rdy;
    upd = 1'b1; ld = 1'b0; nxt = m_pc;
    if (r) begin
      m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0; m_val = 1'b0; m_cnt = 32'h0;
      upd = 1'b0;
    end else if (st) begin
      upd = 1'b0;
    end else if (sjb && m_val) begin
      if (ji_en)      tgt = {m_pc4[31:28], ji, 2'b00};
      else if (jr_en) tgt = {rs[31:2], 2'b00};
      else            tgt = m_pc4 + 32'($signed(m_ins[15:0]) * 4);
`ifdef FETCH_BRANCH_FLUSH_EN
      ld = 1'b0;
`else
      ld = rdy;
`endif
      nxt = tgt;
    end else if (rdy) begin
      ld = 1'b1; nxt = m_pc + 32'd4;
    end
    if (upd) begin
      if (ld) begin
        m_ins = data; m_pc4 = m_pc + 32'd4; m_val = 1'b1; m_cnt = m_cnt + 32'd1;
      end else begin
        m_ins = 32'h0; m_pc4 = 32'h0; m_val = 1'b0;
      end
      m_pc = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 26'h0, 1'b1, 32'h4000, 32'h1234_5678, 1'b1);
    vectors++;
    if ({pc, id_instruction, id_pc_4, id_valid, fetchedCount} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset: got pc=%h ins=%h pc4=%h v=%b cnt=%0d, want all zero", pc, id_instruction, id_pc_4, id_valid, fetchedCount);
    end
    vectors++;
    if (imemAddress !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_imem_addr: got %h want 00000000", imemAddress);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h2001_0005; words[1] = 32'h2002_0007; words[2] = 32'h0022_1820;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, words[i], 1'b1);
      vectors++;
      if ({pc, id_instruction, id_pc_4, id_valid} !== {32'(4 * (i + 1)), words[i], 32'(4 * (i + 1)), 1'b1}) begin
        miscompares++;
        $display("FAIL seq_fetch[%0d]: got pc=%h ins=%h pc4=%h v=%b want pc=ins pc4=%h ins=%h",
                 i, pc, id_instruction, id_pc_4, id_valid, 32'(4 * (i + 1)), words[i]);
      end
    end
    vectors++;
    if (fetchedCount !== 32'd3 || imemAddress !== 32'hC) begin
      miscompares++;
      $display("FAIL seq_count: got cnt=%0d addr=%h want cnt=3 addr=0000000c", fetchedCount, imemAddress);
    end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h8C22_0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 26'h0, 1'b1, 32'h4000, 32'hDEAD_BEEF, 1'b1);
      vectors++;
      if ({pc, id_instruction, id_pc_4, id_valid, fetchedCount} !== {32'h10, 32'h8C22_0000, 32'h10, 1'b1, 32'd4}) begin
        miscompares++;
        $display("FAIL stall[%0d]: got pc=%h ins=%h pc4=%h v=%b cnt=%0d want pc=10 ins=8c220000 pc4=10 v=1 cnt=4",
                 i, pc, id_instruction, id_pc_4, id_valid, fetchedCount);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h1000_FFFE, 1'b1);
    vectors++;
    if ({pc, id_instruction, id_pc_4, fetchedCount} !== {32'h14, 32'h1000_FFFE, 32'h14, 32'd5}) begin
      miscompares++;
      $display("FAIL stall_release: got pc=%h ins=%h pc4=%h cnt=%0d want pc=14 ins=1000fffe pc4=14 cnt=5",
               pc, id_instruction, id_pc_4, fetchedCount);
    end
  endtask

  task automatic test_branch();
    step(1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b0, 32'h0, 32'h2442_0001, 1'b1);
    vectors++;
`ifdef FETCH_BRANCH_FLUSH_EN
    if ({pc, id_instruction, id_pc_4, id_valid, fetchedCount} !== {32'hC, 32'h0, 32'h0, 1'b0, 32'd5}) begin
      miscompares++;
      $display("FAIL branch_flush: got pc=%h ins=%h pc4=%h v=%b cnt=%0d want pc=c bubble cnt=5",
               pc, id_instruction, id_pc_4, id_valid, fetchedCount);
    end
`else
    if ({pc, id_instruction, id_pc_4, id_valid, fetchedCount} !== {32'hC, 32'h2442_0001, 32'h18, 1'b1, 32'd6}) begin
      miscompares++;
      $display("FAIL branch_delay_slot: got pc=%h ins=%h pc4=%h v=%b cnt=%0d want pc=c ins=24420001 pc4=18 v=1 cnt=6",
               pc, id_instruction, id_pc_4, id_valid, fetchedCount);
    end
`endif
  endtask

  task automatic test_jump();
    step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b1, 32'h1000_0007, 32'h0000_0000, 1'b1);
    vectors++;
    if (pc !== 32'h1000_0004) begin
      miscompares++;
      $display("FAIL jr_setup: got pc=%h want 10000004", pc);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0800_0040, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 26'h000_0040, 1'b0, 32'h0, 32'h0000_0000, 1'b1);
    vectors++;
    if (pc !== 32'h1000_0100) begin
      miscompares++;
      $display("FAIL j_target: got pc=%h want 10000100", pc);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b1, 32'h0000_2003, 32'h0000_0000, 1'b1);
    vectors++;
    if ({pc, imemAddress} !== {32'h0000_2000, 32'h0000_2000}) begin
      miscompares++;
      $display("FAIL jr_target: got pc=%h addr=%h want 00002000", pc, imemAddress);
    end
  endtask

  task automatic test_not_ready();
    logic [31:0] cnt0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b1);
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
      vectors++;
      if ({pc, id_instruction, id_pc_4, id_valid, fetchedCount} !== {32'h20, 32'h0, 32'h0, 1'b0, cnt0}) begin
        miscompares++;
        $display("FAIL not_ready[%0d]: got pc=%h ins=%h pc4=%h v=%b cnt=%0d want pc=20 bubble cnt=%0d",
                 i, pc, id_instruction, id_pc_4, id_valid, fetchedCount, cnt0);
      end
    end
    // redirect against a bubble must be ignored
    step(1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b1, 32'h0000_4000, 32'h0, 1'b0);
    vectors++;
    if (pc !== 32'h20) begin
      miscompares++;
      $display("FAIL redirect_on_bubble: got pc=%h want 00000020", pc);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    vectors++;
    if (pc !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_setup: got pc=%h want fffffffc", pc);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 32'hABCD_0123, 1'b1);
    vectors++;
    if ({pc, id_instruction, id_pc_4, id_valid} !== {32'h0, 32'hABCD_0123, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL pc_wrap: got pc=%h ins=%h pc4=%h v=%b want pc=0 ins=abcd0123 pc4=0 v=1",
               pc, id_instruction, id_pc_4, id_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3),
           1'($urandom), 26'($urandom), 1'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0));
      vectors++;
      if ({pc, imemAddress, id_instruction, id_pc_4, id_valid, fetchedCount} !==
          {m_pc, m_pc, m_ins, m_pc4, m_val, m_cnt}) begin
        miscompares++;
        $display("FAIL random[%0d]: got pc=%h ins=%h pc4=%h v=%b cnt=%0d want pc=%h ins=%h pc4=%h v=%b cnt=%0d",
                 i, pc, id_instruction, id_pc_4, id_valid, fetchedCount, m_pc, m_ins, m_pc4, m_val, m_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; shouldStall = 1'b0; shouldJumpOrBranch = 1'b0; isJumpIndex = 1'b0; jumpIndex = '0;
    isJumpRegister = 1'b0; registerRs = '0; imemData = '0; imemReady = 1'b0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_not_ready();
    test_wrap();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
